ecc_result_collector: RTL and testbench
=======================================

// Module: ecc_result_collector
// PURPOSE
// - Consumer end of the ECC block's result interface (data_out, operation_done, num_of_errors).
// - Captures each completed operation into a show-ahead FIFO and keeps saturating per-class error statistics.
// - Sits between the ECC encoder/decoder output and a software/bench reader, which drains results via a valid/pop handshake.
// PARAMETERS
// - DATA_WIDTH  32  width of captured data word; matches the ECC result interface
// - FIFO_DEPTH  8   result entries; power of two, >=2
// - CNT_WIDTH   16  width of each statistics counter
// PORTS
// - PCLK              in   1                 clock, all logic on rising edge
// - PRESETn           in   1                 asynchronous active-low reset
// - data_out_i        in   DATA_WIDTH        result word from ECC block
// - operation_done_i  in   1                 result-valid indication from ECC block
// - num_of_errors_i   in   2                 0 none, 1 single corrected, 2 double detected, 3 illegal
// - clr_i             in   1                 sync clear: flush FIFO, zero counters, clear flags
// - pop_i             in   1                 reader consumes head entry
// - rd_valid_o        out  1                 FIFO non-empty; head entry valid
// - rd_data_o         out  DATA_WIDTH        head entry data
// - rd_errors_o       out  2                 head entry error code
// - fifo_count_o      out  $clog2(DEPTH)+1   entries held, 0..FIFO_DEPTH
// - overflow_o        out  1                 sticky: a result was dropped because FIFO was full
// - illegal_o         out  1                 sticky: num_of_errors_i==3 was captured
// - cnt_none_o        out  CNT_WIDTH         results with 0 errors
// - cnt_single_o      out  CNT_WIDTH         results with 1 error
// - cnt_double_o      out  CNT_WIDTH         results with 2 errors
// BEHAVIOUR
// - Reset (PRESETn low, async): FIFO empty, all outputs 0, done-edge register 0.
// - Capture event = rising edge of operation_done_i (registered previous value); a level held N cycles captures once.
// - Capture samples data_out_i and num_of_errors_i in the same cycle operation_done_i first goes high.
// - Push on capture when not full; entry visible (rd_valid_o=1, fifo_count_o+1) the cycle after capture.
// - Capture while full and no pop: entry dropped, overflow_o set, counters still updated.
// - Capture while full with pop same cycle: pop frees slot, push accepted, count unchanged.
// - Show-ahead read: rd_data_o/rd_errors_o = head whenever rd_valid_o=1; pop takes effect on edge where rd_valid_o & pop_i.
// - Pop while empty ignored; no underflow, count stays 0.
// - Simultaneous push and pop on non-empty, non-full FIFO: count unchanged, order preserved.
// - Pointers wrap modulo FIFO_DEPTH; full/empty from count, not pointer equality alone.
// - Counters: code 0/1/2 increments matching counter by 1; saturate at 2^CNT_WIDTH-1, never wrap.
// - Code 3: no counter increments; illegal_o set; entry still pushed for inspection.
// - clr_i: next cycle FIFO empty, counters 0, overflow_o/illegal_o 0; clr_i overrides capture and pop in same cycle.
// - Reset mid-stream: all state lost immediately; first capture after release needs a fresh rising edge of operation_done_i.
// - All outputs registered except rd_data_o/rd_errors_o (direct FIFO memory read of head).
// STRUCTURE
// - Package ecc_collector_pkg: enum err_code_t {ERR_NONE=0, ERR_SINGLE=1, ERR_DOUBLE=2, ERR_ILLEGAL=3};
//   struct result_t {logic [DATA_WIDTH-1:0] data; err_code_t errors;}; default width constants.
// - Sub-module sync_fifo (param WIDTH, DEPTH): push/pop/full/empty/count, show-ahead head output.
// - Top: done edge detector, statistics counters, sticky flags, clr handling.
// TESTING
// - Reset, then 3 done pulses with codes 0,1,2, data 0xA5A5_0001.. -> count=3, cnt_none/single/double=1/1/1, pops return same order.
// - Hold operation_done_i high 5 cycles, code 1 -> exactly one entry, cnt_single=1.
// - 9 captures, no pops, DEPTH=8 -> count=8, overflow_o=1, 9th data absent, cnt totals=9.
// - Full FIFO, capture+pop same cycle -> count stays 8, new word at tail, oldest removed.
// - Capture code 3 -> illegal_o=1, entry present with rd_errors_o=3, no counter change; clr_i -> all zero next cycle.
// - Force cnt_none to 0xFFFF via 65536 code-0 captures with pops -> stays 0xFFFF; PRESETn low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ecc_result_collector_pkg.sv
// Shared types and defaults for the ECC result collector.
package ecc_collector_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SINGLE  = 2'd1,
    ERR_DOUBLE  = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_code_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    err_code_t                 errors;
  } result_t;

  function automatic err_code_t to_err_code(input logic [1:0] code);
    return err_code_t'(code);
  endfunction

endpackage

// File: rtl/ecc_result_collector_sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy is tracked by an explicit count so
// full/empty never depend on pointer equality.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/ecc_result_collector.sv
// Collects ECC results on the rising edge of operation_done_i into a FIFO
// and keeps saturating per-class error statistics plus sticky fault flags.
module ecc_result_collector
  import ecc_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [DATA_WIDTH-1:0]         data_out_i,
  input  logic                          operation_done_i,
  input  logic [1:0]                    num_of_errors_i,
  input  logic                          clr_i,
  input  logic                          pop_i,
  output logic                          rd_valid_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [1:0]                    rd_errors_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic                          illegal_o,
  output logic [CNT_WIDTH-1:0]          cnt_none_o,
  output logic [CNT_WIDTH-1:0]          cnt_single_o,
  output logic [CNT_WIDTH-1:0]          cnt_double_o
);

  localparam int FW = DATA_WIDTH + 2;

  logic            done_prev_reg;
  logic            capture_ok;
  logic            pop_ok;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   head;
  err_code_t       cap_code;
  logic [CNT_WIDTH-1:0] cnt_vals [3];

  // clr_i wins over both capture and pop in the same cycle.
  assign capture_ok = operation_done_i & ~done_prev_reg & ~clr_i;
  assign pop_ok     = pop_i & ~fifo_empty & ~clr_i;
  assign cap_code   = to_err_code(num_of_errors_i);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clr     (clr_i),
    .push    (capture_ok),
    .pop     (pop_ok),
    .wr_data ({num_of_errors_i, data_out_i}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_o)
  );

  assign rd_valid_o  = ~fifo_empty;
  assign rd_data_o   = head[DATA_WIDTH-1:0];
  assign rd_errors_o = head[FW-1 -: 2];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done_prev_reg <= 1'b0;
      overflow_o    <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      done_prev_reg <= operation_done_i;
      if (clr_i) begin
        overflow_o <= 1'b0;
        illegal_o  <= 1'b0;
      end else begin
        if (capture_ok && fifo_full && !pop_ok) overflow_o <= 1'b1;
        if (capture_ok && cap_code == ERR_ILLEGAL) illegal_o <= 1'b1;
      end
    end
  end

  // One saturating counter per legal error class; illegal codes never match.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        cnt_reg <= '0;
      end else if (clr_i) begin
        cnt_reg <= '0;
      end else if (capture_ok && num_of_errors_i == 2'(gi) && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign cnt_vals[gi] = cnt_reg;
  end

  assign cnt_none_o   = cnt_vals[0];
  assign cnt_single_o = cnt_vals[1];
  assign cnt_double_o = cnt_vals[2];

endmodule

// File: tb/tb_ecc_result_collector.sv
// Directed scoreboard bench for ecc_result_collector; counters are narrowed
// so saturation is reachable in a short run.
module tb_ecc_result_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int FCW   = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [DW-1:0]   data_out_i;
  logic            operation_done_i;
  logic [1:0]      num_of_errors_i;
  logic            clr_i;
  logic            pop_i;
  logic            rd_valid_o;
  logic [DW-1:0]   rd_data_o;
  logic [1:0]      rd_errors_o;
  logic [FCW-1:0]  fifo_count_o;
  logic            overflow_o;
  logic            illegal_o;
  logic [CW-1:0]   cnt_none_o;
  logic [CW-1:0]   cnt_single_o;
  logic [CW-1:0]   cnt_double_o;

  int tests = 0;
  int fails = 0;

  logic [DW+1:0] sb_q[$];
  int            exp_cnt[3];
  bit            exp_ovf;
  bit            exp_ill;

  ecc_result_collector #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .PCLK             (PCLK),
    .PRESETn          (PRESETn),
    .data_out_i       (data_out_i),
    .operation_done_i (operation_done_i),
    .num_of_errors_i  (num_of_errors_i),
    .clr_i            (clr_i),
    .pop_i            (pop_i),
    .rd_valid_o       (rd_valid_o),
    .rd_data_o        (rd_data_o),
    .rd_errors_o      (rd_errors_o),
    .fifo_count_o     (fifo_count_o),
    .overflow_o       (overflow_o),
    .illegal_o        (illegal_o),
    .cnt_none_o       (cnt_none_o),
    .cnt_single_o     (cnt_single_o),
    .cnt_double_o     (cnt_double_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    exp_ovf = 1'b0;
    exp_ill = 1'b0;
  endtask

  task automatic model_capture(input logic [DW-1:0] d, input logic [1:0] code);
    if (code == 2'd3) exp_ill = 1'b1;
    else if (exp_cnt[code] < CMAX) exp_cnt[code]++;
    if (sb_q.size() < DEPTH) sb_q.push_back({code, d});
    else exp_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    logic [DW+1:0] head;
    chk({tag, ".count"},    64'(fifo_count_o), 64'(sb_q.size()));
    chk({tag, ".valid"},    64'(rd_valid_o),   64'(sb_q.size() != 0));
    chk({tag, ".overflow"}, 64'(overflow_o),   64'(exp_ovf));
    chk({tag, ".illegal"},  64'(illegal_o),    64'(exp_ill));
    chk({tag, ".cnt_none"}, 64'(cnt_none_o),   64'(exp_cnt[0]));
    chk({tag, ".cnt_single"}, 64'(cnt_single_o), 64'(exp_cnt[1]));
    chk({tag, ".cnt_double"}, 64'(cnt_double_o), 64'(exp_cnt[2]));
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      chk({tag, ".head_data"}, 64'(rd_data_o),   64'(head[DW-1:0]));
      chk({tag, ".head_err"},  64'(rd_errors_o), 64'(head[DW+1:DW]));
    end
  endtask

  // Starts and ends on a falling edge; data changes after the first cycle.
  task automatic capture(input logic [DW-1:0] d, input logic [1:0] code, input int hold);
    operation_done_i = 1'b1;
    data_out_i       = d;
    num_of_errors_i  = code;
    @(negedge PCLK);
    for (int i = 1; i < hold; i++) begin
      data_out_i      = $urandom;
      num_of_errors_i = 2'($urandom_range(0, 3));
      @(negedge PCLK);
    end
    operation_done_i = 1'b0;
    data_out_i       = $urandom;
    num_of_errors_i  = 2'($urandom_range(0, 3));
    @(negedge PCLK);
    model_capture(d, code);
  endtask

  task automatic pop_one(input string tag);
    logic [DW+1:0] head;
    head = sb_q.pop_front();
    chk({tag, ".pop_valid"}, 64'(rd_valid_o),  64'd1);
    chk({tag, ".pop_data"},  64'(rd_data_o),   64'(head[DW-1:0]));
    chk({tag, ".pop_err"},   64'(rd_errors_o), 64'(head[DW+1:DW]));
    pop_i = 1'b1;
    @(negedge PCLK);
    pop_i = 1'b0;
  endtask

  task automatic pop_empty(input string tag);
    pop_i = 1'b1;
    @(negedge PCLK);
    pop_i = 1'b0;
    chk({tag, ".empty_count"}, 64'(fifo_count_o), 64'd0);
    chk({tag, ".empty_valid"}, 64'(rd_valid_o),   64'd0);
  endtask

  task automatic capture_pop(input string tag, input logic [DW-1:0] d, input logic [1:0] code);
    logic [DW+1:0] head;
    head = sb_q.pop_front();
    chk({tag, ".cp_head"}, 64'(rd_data_o), 64'(head[DW-1:0]));
    operation_done_i = 1'b1;
    pop_i            = 1'b1;
    data_out_i       = d;
    num_of_errors_i  = code;
    @(negedge PCLK);
    operation_done_i = 1'b0;
    pop_i            = 1'b0;
    @(negedge PCLK);
    model_capture(d, code);
  endtask

  // Clear is issued together with a fresh capture and a pop to show it wins.
  task automatic do_clear(input string tag);
    clr_i            = 1'b1;
    pop_i            = 1'b1;
    operation_done_i = 1'b1;
    data_out_i       = 32'hDEAD_BEEF;
    num_of_errors_i  = 2'd3;
    @(negedge PCLK);
    clr_i            = 1'b0;
    pop_i            = 1'b0;
    operation_done_i = 1'b0;
    model_reset();
    check_state(tag);
    @(negedge PCLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0;
    data_out_i = '0;
    operation_done_i = 1'b0;
    num_of_errors_i = '0;
    clr_i = 1'b0;
    pop_i = 1'b0;
    model_reset();
    repeat (3) @(negedge PCLK);
    check_state("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);

    capture(32'hA5A5_0001, 2'd0, 1);
    capture(32'hA5A5_0002, 2'd1, 1);
    capture(32'hA5A5_0003, 2'd2, 1);
    check_state("three");
    repeat (3) pop_one("three");
    check_state("three_drained");

    capture(32'hB0B0_0005, 2'd1, 5);
    check_state("hold5");
    pop_one("hold5");
    pop_empty("hold5");

    do_clear("clr1");

    for (int i = 0; i < 9; i++) capture(32'hC000_0000 + i, 2'(i % 3), 1);
    check_state("overflow");

    capture_pop("full", 32'hD00D_0009, 2'd1);
    check_state("full_cp");
    while (sb_q.size() != 0) pop_one("full_drain");
    pop_empty("full_drain");

    do_clear("clr2");
    capture(32'hE0E0_0003, 2'd3, 1);
    check_state("illegal");
    do_clear("clr3");

    for (int i = 0; i < CMAX + 5; i++) capture(32'hF000_0000 + i, 2'd0, 1);
    check_state("saturate");
    capture_pop("sat", 32'hF1F1_0000, 2'd0);
    check_state("sat_cp");

    operation_done_i = 1'b1;
    data_out_i = 32'h1234_5678;
    @(posedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    model_reset();
    chk("areset.count",    64'(fifo_count_o), 64'd0);
    chk("areset.valid",    64'(rd_valid_o),   64'd0);
    chk("areset.data",     64'(rd_data_o),    64'd0);
    chk("areset.errors",   64'(rd_errors_o),  64'd0);
    chk("areset.overflow", 64'(overflow_o),   64'd0);
    chk("areset.cnt_none", 64'(cnt_none_o),   64'd0);
    @(negedge PCLK);
    operation_done_i = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_state("post_reset");
    capture(32'h5555_AAAA, 2'd2, 1);
    check_state("post_reset_cap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
